paddle_position_tracker: RTL and testbench
==========================================

Name: paddle_position_tracker

Overview:
Downstream consumer of the per-paddle movement stage. Integrates the signed 2-bit per-tick position_change stream into an absolute paddle top-edge Y coordinate and clamps it to the playfield. It latches a frame-stable copy for the renderer and provides a serve-time recenter sequence that glides the paddle back to mid-screen. One instance per player, between the paddle movement stage and the renderer/collision logic.

Parameters:
SCREEN_HEIGHT, 480, visible lines; Y = 0 is the top row.
PADDLE_HEIGHT, 64, paddle height in lines; must be < SCREEN_HEIGHT (elaboration-time check).
RECENTER_STEP_CLOCKS, 100000, clocks per 1-pixel move during recenter; must be >= 1 (elaboration-time check).
Derived localparams: Y_WIDTH = $clog2(SCREEN_HEIGHT); MAX_Y = SCREEN_HEIGHT - PADDLE_HEIGHT; CENTER_Y = MAX_Y / 2, floored.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
position_change  input  2 signed  per-cycle move: +1 = one line down (Y+1), -1 = one line up, 0 = hold.
frame_start  input  1  one-cycle pulse at start of vertical blank.
recenter_req  input  1  one-cycle pulse requesting a glide to CENTER_Y.
live_y  output  Y_WIDTH  registered current paddle top Y.
paddle_y  output  Y_WIDTH  frame-latched paddle top Y for renderer/collision.
at_top  output  1  live_y == 0 (combinational from the live_y register).
at_bottom  output  1  live_y == MAX_Y (combinational from the live_y register).
recenter_busy  output  1  high while in RECENTER.
recenter_done  output  1  registered one-cycle pulse when the recenter completes.

Behaviour:
- Reset (clk edge with rst = 1): live_y = paddle_y = CENTER_Y; state = TRACK; step counter = 0; recenter_busy = 0; recenter_done = 0. rst overrides every other input, including mid-recenter.
- FSM states: TRACK, RECENTER.
- TRACK:
  - Each cycle, live_y <= clamp(live_y + position_change, 0, MAX_Y). Latency is 1 cycle.
  - Arithmetic is done at Y_WIDTH+2 bits signed, then clamped. There is no wrap at 0 or MAX_Y: -1 at 0 holds 0, and +1 at MAX_Y holds MAX_Y.
  - position_change = 2'b10 (-2) is illegal and is treated as 0.
- recenter_req in TRACK:
  - Next state is RECENTER and the step counter clears.
  - The position_change sampled in that same cycle is still applied.
- RECENTER:
  - recenter_busy = 1. position_change and further recenter_req pulses are ignored.
  - Each cycle, first check live_y == CENTER_Y. If equal: next state TRACK, recenter_done <= 1 for exactly one cycle, counter cleared.
  - Otherwise, increment the counter. When it reaches RECENTER_STEP_CLOCKS-1, move live_y one line toward CENTER_Y and reset the counter to 0.
- Frame latch:
  - On a cycle with frame_start = 1, paddle_y <= the live_y register value from that cycle, before that cycle's update. Otherwise paddle_y holds.
  - Operates identically in both states.
  - frame_start together with position_change: paddle_y takes the pre-update value.
- Timing: recenter_req is high in cycle k, and recenter_busy rises in cycle k+1.
  - If already centered, recenter_done is high and recenter_busy is low in cycle k+2.
  - If N lines away, recenter_done fires at cycle k+2+N*RECENTER_STEP_CLOCKS.

Test Plan:
Use SCREEN_HEIGHT=480, PADDLE_HEIGHT=64 (MAX_Y=416, CENTER_Y=208), RECENTER_STEP_CLOCKS=4.
1. Assert rst for 2 cycles, then release -> live_y = paddle_y = 208; recenter_busy, recenter_done, at_top and at_bottom all 0. Assert rst again mid-recenter -> same values next cycle.
2. Hold position_change=+1 for 300 cycles -> live_y reaches 416 after 208 cycles, stays 416, at_bottom=1. Then hold -1 for 500 cycles -> live_y reaches 0, stays 0, at_top=1. Drive 2'b10 for 5 cycles -> live_y unchanged.
3. From live_y=208, drive +1 for 10 cycles, with frame_start on the 5th of those cycles -> paddle_y = 212 (held until the next frame_start); live_y = 218 at the end.
4. Move live_y to 216, then pulse recenter_req while holding position_change=-1 throughout -> busy the next cycle; live_y decrements 1 every 4 cycles; reaches 208 after 32 RECENTER cycles; recenter_done is a single-cycle pulse; the -1 input has no effect. Extra recenter_req pulses during RECENTER are ignored.
5. At live_y=208, pulse recenter_req -> recenter_busy high for exactly 1 cycle; recenter_done high 2 cycles after the request; live_y stays 208.
6. Starting from live_y=0, recenter with frame_start pulsed every 20 cycles -> paddle_y samples 0, then 5, 10, … (monotonic, never exceeding 208); completion after 208*4 + 2 cycles.

Source files
------------

// File: rtl/paddle_position_tracker.sv
// Integrates the signed per-tick paddle movement into a clamped top-edge Y,
// latches a frame-stable copy, and glides the paddle to mid-screen on request.
module paddle_position_tracker #(
  parameter int SCREEN_HEIGHT        = 480,
  parameter int PADDLE_HEIGHT        = 64,
  parameter int RECENTER_STEP_CLOCKS = 100000,
  localparam int Y_WIDTH             = $clog2(SCREEN_HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [1:0]   position_change,
  input  logic                frame_start,
  input  logic                recenter_req,
  output logic [Y_WIDTH-1:0]  live_y,
  output logic [Y_WIDTH-1:0]  paddle_y,
  output logic                at_top,
  output logic                at_bottom,
  output logic                recenter_busy,
  output logic                recenter_done
);

  localparam int MAX_Y    = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int CENTER_Y = MAX_Y / 2;
  localparam int CNT_W    = (RECENTER_STEP_CLOCKS > 1) ? $clog2(RECENTER_STEP_CLOCKS) : 1;

  localparam logic [Y_WIDTH-1:0]          MAX_Y_L    = Y_WIDTH'(MAX_Y);
  localparam logic [Y_WIDTH-1:0]          CENTER_Y_L = Y_WIDTH'(CENTER_Y);
  localparam logic signed [Y_WIDTH+1:0]   MAX_Y_S    = (Y_WIDTH+2)'(MAX_Y);
  localparam logic [CNT_W-1:0]            CNT_LAST   = CNT_W'(RECENTER_STEP_CLOCKS - 1);

  if (PADDLE_HEIGHT >= SCREEN_HEIGHT) begin : g_bad_height
    $error("PADDLE_HEIGHT must be smaller than SCREEN_HEIGHT");
  end
  if (RECENTER_STEP_CLOCKS < 1) begin : g_bad_step
    $error("RECENTER_STEP_CLOCKS must be at least 1");
  end

  typedef enum logic [0:0] {
    TRACK    = 1'b0,
    RECENTER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [Y_WIDTH-1:0]  live_y_q, live_y_d;
  logic [Y_WIDTH-1:0]  paddle_y_q, paddle_y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  logic signed [Y_WIDTH+1:0] delta;
  logic signed [Y_WIDTH+1:0] sum;
  logic [Y_WIDTH-1:0]        clamped;

  // 2'b10 (-2) is not a legal move and is treated as hold.
  assign delta   = (position_change == 2'b10) ? '0
                 : {{Y_WIDTH{position_change[1]}}, position_change};
  assign sum     = $signed({2'b00, live_y_q}) + delta;
  assign clamped = (sum < 0)       ? '0
                 : (sum > MAX_Y_S) ? MAX_Y_L
                 : sum[Y_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    live_y_d   = live_y_q;
    paddle_y_d = frame_start ? live_y_q : paddle_y_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    case (state_q)
      TRACK: begin
        live_y_d = clamped;
        if (recenter_req) begin
          state_d = RECENTER;
          cnt_d   = '0;
        end
      end
      RECENTER: begin
        // Centre check precedes stepping, so completion costs one extra cycle.
        if (live_y_q == CENTER_Y_L) begin
          state_d = TRACK;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          live_y_d = (live_y_q > CENTER_Y_L) ? live_y_q - 1'b1 : live_y_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TRACK;
      live_y_q   <= CENTER_Y_L;
      paddle_y_q <= CENTER_Y_L;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_y_q   <= live_y_d;
      paddle_y_q <= paddle_y_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign live_y        = live_y_q;
  assign paddle_y      = paddle_y_q;
  assign at_top        = (live_y_q == '0);
  assign at_bottom     = (live_y_q == MAX_Y_L);
  assign recenter_busy = (state_q == RECENTER);
  assign recenter_done = done_q;

endmodule

// File: tb/tb_paddle_position_tracker.sv
// Directed bench for paddle_position_tracker with 480/64 geometry and a
// 4-clock recenter step (MAX_Y = 416, CENTER_Y = 208).
module tb_paddle_position_tracker;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [1:0] position_change;
  logic              frame_start;
  logic              recenter_req;
  logic [8:0]        live_y;
  logic [8:0]        paddle_y;
  logic              at_top;
  logic              at_bottom;
  logic              recenter_busy;
  logic              recenter_done;

  int vectors     = 0;
  int miscompares = 0;

  paddle_position_tracker #(
    .SCREEN_HEIGHT       (480),
    .PADDLE_HEIGHT       (64),
    .RECENTER_STEP_CLOCKS(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .position_change(position_change),
    .frame_start    (frame_start),
    .recenter_req   (recenter_req),
    .live_y         (live_y),
    .paddle_y       (paddle_y),
    .at_top         (at_top),
    .at_bottom      (at_bottom),
    .recenter_busy  (recenter_busy),
    .recenter_done  (recenter_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; position_change = 2'b00; frame_start = 1'b0; recenter_req = 1'b0;

    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst_live", live_y, 208);
    chk("rst_paddle", paddle_y, 208);
    chk("rst_busy", recenter_busy, 0);
    chk("rst_done", recenter_done, 0);
    chk("rst_top", at_top, 0);
    chk("rst_bottom", at_bottom, 0);
    tick(1);
    chk("rel_live", live_y, 208);

    // Clamp at bottom
    position_change = 2'b01;
    tick(207);
    chk("down_415", live_y, 415);
    chk("down_415_bot", at_bottom, 0);
    tick(1);
    chk("down_416", live_y, 416);
    chk("down_416_bot", at_bottom, 1);
    tick(92);
    chk("down_hold", live_y, 416);
    chk("down_hold_bot", at_bottom, 1);

    // Clamp at top
    position_change = 2'b11;
    tick(415);
    chk("up_1", live_y, 1);
    chk("up_1_top", at_top, 0);
    tick(1);
    chk("up_0", live_y, 0);
    chk("up_0_top", at_top, 1);
    tick(84);
    chk("up_hold", live_y, 0);
    chk("up_hold_bot", at_bottom, 0);
    position_change = 2'b10;
    tick(5);
    chk("illegal_at_0", live_y, 0);

    // Back to centre via reset, illegal code mid-range
    position_change = 2'b00;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_live", live_y, 208);
    position_change = 2'b10;
    tick(5);
    chk("illegal_mid", live_y, 208);

    // Frame latch takes the pre-update value
    position_change = 2'b01;
    tick(4);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk("frame_paddle", paddle_y, 212);
    chk("frame_live", live_y, 213);
    tick(5);
    chk("frame_end_live", live_y, 218);
    chk("frame_hold_paddle", paddle_y, 212);

    // Recenter from 216 with -1 held; the request-cycle move still applies
    position_change = 2'b11;
    tick(1);
    chk("pre_rc_live", live_y, 217);
    recenter_req = 1'b1;
    tick(1);
    recenter_req = 1'b0;
    chk("rc_entry_live", live_y, 216);
    chk("rc_entry_busy", recenter_busy, 1);
    tick(3);
    chk("rc_e3_live", live_y, 216);
    tick(1);
    chk("rc_e4_live", live_y, 215);
    recenter_req = 1'b1;
    tick(1);
    recenter_req = 1'b0;
    chk("rc_extra_busy", recenter_busy, 1);
    tick(26);
    chk("rc_e31_live", live_y, 209);
    tick(1);
    chk("rc_e32_live", live_y, 208);
    chk("rc_e32_busy", recenter_busy, 1);
    chk("rc_e32_done", recenter_done, 0);
    tick(1);
    position_change = 2'b00;
    chk("rc_done", recenter_done, 1);
    chk("rc_done_busy", recenter_busy, 0);
    chk("rc_done_live", live_y, 208);
    tick(1);
    chk("rc_done_pulse", recenter_done, 0);
    chk("rc_after_live", live_y, 208);

    // Recenter when already centred
    recenter_req = 1'b1;
    tick(1);
    recenter_req = 1'b0;
    chk("cen_busy", recenter_busy, 1);
    chk("cen_done0", recenter_done, 0);
    tick(1);
    chk("cen_busy_off", recenter_busy, 0);
    chk("cen_done", recenter_done, 1);
    chk("cen_live", live_y, 208);
    tick(1);
    chk("cen_done_off", recenter_done, 0);

    // Long recenter from 0 with periodic frame latches
    position_change = 2'b11;
    tick(208);
    position_change = 2'b00;
    chk("long_start", live_y, 0);
    recenter_req = 1'b1;
    tick(1);
    recenter_req = 1'b0;
    for (int i = 0; i < 42; i++) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      chk($sformatf("long_paddle_%0d", i), paddle_y, 5 * i);
      chk($sformatf("long_live_%0d", i), live_y, 5 * i);
      if (i < 41) tick(19);
    end
    tick(11);
    chk("long_e832_live", live_y, 208);
    chk("long_e832_busy", recenter_busy, 1);
    chk("long_e832_done", recenter_done, 0);
    tick(1);
    chk("long_done", recenter_done, 1);
    chk("long_done_busy", recenter_busy, 0);

    // Reset in the middle of a recenter
    position_change = 2'b01;
    tick(10);
    position_change = 2'b00;
    chk("mid_pre_live", live_y, 218);
    recenter_req = 1'b1;
    tick(1);
    recenter_req = 1'b0;
    tick(5);
    chk("mid_live", live_y, 217);
    chk("mid_busy", recenter_busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_live", live_y, 208);
    chk("mid_rst_paddle", paddle_y, 208);
    chk("mid_rst_busy", recenter_busy, 0);
    chk("mid_rst_done", recenter_done, 0);
    chk("mid_rst_top", at_top, 0);
    chk("mid_rst_bottom", at_bottom, 0);
    tick(3);
    chk("mid_post_busy", recenter_busy, 0);
    chk("mid_post_done", recenter_done, 0);
    chk("mid_post_live", live_y, 208);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
